// File: rtl/flow_led_ctrl.sv
// Flowing-water LED controller: step prescaler, position/direction state and
// pattern decode (rotate left, rotate right, ping-pong bounce, thermometer bar).
module flow_led_ctrl #(
  parameter int N_LED = 8,
  parameter int DIV   = 25_000_000,
  parameter int PW    = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] led,
  output logic [PW-1:0]    pos,
  output logic             step
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(N_LED - 1);

  typedef enum logic [1:0] {LEFT = 2'b00, RIGHT = 2'b01, BOUNCE = 2'b10, BAR = 2'b11} mode_t;
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  logic [CW-1:0] cnt, cnt_d;
  logic [PW-1:0] pos_d;
  dir_t          dir, dir_d;
  mode_t         mode_q, mode_d;
  logic          step_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      pos    <= '0;
      dir    <= UP;
      mode_q <= LEFT;
      step   <= 1'b0;
    end else begin
      cnt    <= cnt_d;
      pos    <= pos_d;
      dir    <= dir_d;
      mode_q <= mode_d;
      step   <= step_d;
    end
  end

  // The mode pin is sampled only on a step edge and applied to the old pos.
  always_comb begin
    cnt_d  = cnt;
    pos_d  = pos;
    dir_d  = dir;
    mode_d = mode_q;
    step_d = 1'b0;
    if (en) begin
      if (cnt == CNT_MAX) begin
        cnt_d  = '0;
        step_d = 1'b1;
        mode_d = mode_t'(mode);
        dir_d  = UP;
        unique case (mode_t'(mode))
          LEFT, BAR: pos_d = (pos == POS_LAST) ? '0 : pos + PW'(1);
          RIGHT:     pos_d = (pos == '0) ? POS_LAST : pos - PW'(1);
          BOUNCE: begin
            if (dir == UP) begin
              if (pos == POS_LAST) begin
                dir_d = DOWN;
                pos_d = POS_LAST - PW'(1);
              end else begin
                dir_d = UP;
                pos_d = pos + PW'(1);
              end
            end else begin
              if (pos == '0) begin
                dir_d = UP;
                pos_d = PW'(1);
              end else begin
                dir_d = DOWN;
                pos_d = pos - PW'(1);
              end
            end
          end
        endcase
      end else begin
        cnt_d = cnt + CW'(1);
      end
    end
  end

  // Decode uses registered state only, so mode pin changes cannot glitch led.
  always_comb begin
    led = '0;
    for (int i = 0; i < N_LED; i++) begin
      if (mode_q == BAR) led[i] = (PW'(i) <= pos);
      else               led[i] = (PW'(i) == pos);
    end
  end

endmodule

// File: tb/tb_flow_led_ctrl.sv
// Scoreboard bench for flow_led_ctrl: four configurations share one stimulus
// stream; a spec-level model queues expected step results for a monitor.
module tb_flow_led_ctrl;

  typedef struct packed {
    logic [2:0] pos;
    logic [7:0] led;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] mode;
  logic       mon_on = 1'b0;

  logic [7:0] led0; logic [2:0] pos0; logic step0;
  logic [4:0] led1; logic [2:0] pos1; logic step1;
  logic [3:0] led2; logic [1:0] pos2; logic step2;
  logic [5:0] led3; logic [2:0] pos3; logic step3;

  logic [7:0] dled [4];
  logic [2:0] dpos [4];
  logic       dstep[4];

  int ncmp = 0;
  int nerr = 0;

  exp_t sbq[4][$];
  logic [2:0] cur_pos[4];
  logic [7:0] cur_led[4];

  int m_acc[4], m_pos[4], m_ph[4], m_modeq[4];

  always #5 clk = ~clk;

  flow_led_ctrl #(.N_LED(8), .DIV(4)) u0 (.clk(clk), .rst(rst), .en(en), .mode(mode), .led(led0), .pos(pos0), .step(step0));
  flow_led_ctrl #(.N_LED(5), .DIV(1)) u1 (.clk(clk), .rst(rst), .en(en), .mode(mode), .led(led1), .pos(pos1), .step(step1));
  flow_led_ctrl #(.N_LED(4), .DIV(2)) u2 (.clk(clk), .rst(rst), .en(en), .mode(mode), .led(led2), .pos(pos2), .step(step2));
  flow_led_ctrl #(.N_LED(6), .DIV(5)) u3 (.clk(clk), .rst(rst), .en(en), .mode(mode), .led(led3), .pos(pos3), .step(step3));

  assign dled[0] = led0;       assign dpos[0] = pos0;       assign dstep[0] = step0;
  assign dled[1] = 8'(led1);   assign dpos[1] = pos1;       assign dstep[1] = step1;
  assign dled[2] = 8'(led2);   assign dpos[2] = 3'(pos2);   assign dstep[2] = step2;
  assign dled[3] = 8'(led3);   assign dpos[3] = pos3;       assign dstep[3] = step3;

  function automatic int n_of(int k);
    case (k) 0: return 8; 1: return 5; 2: return 4; default: return 6; endcase
  endfunction

  function automatic int d_of(int k);
    case (k) 0: return 4; 1: return 1; 2: return 2; default: return 5; endcase
  endfunction

  task automatic chk(string name, int k, logic [7:0] act, logic [7:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  // Bounce is modelled as a triangle wave over a phase of period 2*(n-1);
  // any other mode leaves the phase equal to pos, i.e. heading upward.
  task automatic model_edge();
    int n, p;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      n = n_of(k);
      if (rst) begin
        m_acc[k] = 0; m_pos[k] = 0; m_ph[k] = 0; m_modeq[k] = 0;
      end else if (en) begin
        m_acc[k]++;
        if (m_acc[k] == d_of(k)) begin
          m_acc[k] = 0;
          m_modeq[k] = int'(mode);
          case (mode)
            2'b01:   p = (m_pos[k] + n - 1) % n;
            2'b10: begin
              m_ph[k] = (m_ph[k] + 1) % (2 * (n - 1));
              p = (m_ph[k] < n) ? m_ph[k] : 2 * (n - 1) - m_ph[k];
            end
            default: p = (m_pos[k] + 1) % n;
          endcase
          m_pos[k] = p;
          if (mode != 2'b10) m_ph[k] = p;
          e.pos = 3'(p);
          e.led = (m_modeq[k] == 3) ? 8'((1 << (p + 1)) - 1) : 8'(1 << p);
          sbq[k].push_back(e);
        end
      end
    end
  endtask

  task automatic drive(logic r, logic e, logic [1:0] m);
    rst = r; en = e; mode = m;
    model_edge();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int k = 0; k < 4; k++) begin
        if (rst) begin
          cur_pos[k] = 3'd0;
          cur_led[k] = 8'h01;
          chk("reset_step", k, 8'(dstep[k]), 8'h00);
        end else if (dstep[k]) begin
          if (sbq[k].size() == 0) begin
            chk("unexpected_step", k, 8'h01, 8'h00);
          end else begin
            exp_t e;
            e = sbq[k].pop_front();
            cur_pos[k] = e.pos;
            cur_led[k] = e.led;
          end
        end else if (sbq[k].size() != 0) begin
          exp_t e;
          chk("missing_step", k, 8'h00, 8'h01);
          e = sbq[k].pop_front();
          cur_pos[k] = e.pos;
          cur_led[k] = e.led;
        end
        chk("pos", k, 8'(dpos[k]), 8'(cur_pos[k]));
        chk("led", k, dled[k], cur_led[k]);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b11;
    for (int k = 0; k < 4; k++) begin
      m_acc[k] = 0; m_pos[k] = 0; m_ph[k] = 0; m_modeq[k] = 0;
      cur_pos[k] = 3'd0; cur_led[k] = 8'h01;
    end
    mon_on = 1'b1;
    repeat (2)  drive(1'b1, 1'b1, 2'b11);
    repeat (20) drive(1'b0, 1'b0, 2'b11);
    repeat (40) drive(1'b0, 1'b1, 2'b00);
    // 40 enabled edges at DIV=4 from reset: ten steps, wrapped once past LED 7.
    chk("left_wrap_pos", 0, 8'(pos0), 8'd2);
    chk("left_wrap_led", 0, led0, 8'h04);
    repeat (30) drive(1'b0, 1'b1, 2'b10);
    repeat (12) drive(1'b0, 1'b1, 2'b11);
    repeat (3)  drive(1'b0, 1'b1, 2'b01);
    repeat (10) drive(1'b0, 1'b0, 2'b01);
    repeat (2)  drive(1'b0, 1'b1, 2'b01);
    repeat (17) drive(1'b0, 1'b1, 2'b10);
    drive(1'b1, 1'b1, 2'b10);
    repeat (10) drive(1'b0, 1'b1, 2'b10);
    begin
      logic [1:0] m;
      m = 2'b00;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(15) == 0) m = 2'($urandom_range(3));
        drive($urandom_range(199) == 0, $urandom_range(9) < 8, m);
      end
    end
    repeat (3) drive(1'b0, 1'b0, 2'b00);
    for (int k = 0; k < 4; k++) chk("queue_drained", k, 8'(sbq[k].size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/flow_led_ctrl.md
# flow_led_ctrl

Parametrised flowing-water LED controller for the board LED bank: N_LED outputs, a built-in step prescaler, and four run-time-selectable patterns (rotate left, rotate right, ping-pong bounce, thermometer bar). It supersedes the fixed 8-way index-to-one-hot LED decoder in the lab designs. It absorbs the step counter, the position state and the pattern decode into one synchronous block that drives the LED pins directly.

## Interface
- N_LED, 8, number of LEDs driven; legal range ≥ 2.
- DIV, 25_000_000, clock cycles per pattern step; legal range ≥ 1.
- PW, max(1, $clog2(N_LED)), position width (derived; do not override).

- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high; wins over every other input.
- en  in  1  run enable; 0 freezes prescaler and pattern.
- mode  in  2  pattern select: 00 LEFT, 01 RIGHT, 10 BOUNCE, 11 BAR.
- led  out  N_LED  LED drive; bit i lights LED i.
- pos  out  PW  current position index, 0..N_LED-1.
- step  out  1  one-cycle pulse; high in the cycle the new pattern first appears on led.

## Operation
- State registers:
  - cnt: prescaler, 0..DIV-1, width $clog2(DIV) (minimum 1).
  - pos: position, PW bits.
  - dir: UP/DOWN.
  - mode_q: applied mode.
  - step: registered pulse.
- Prescaler, on each clk edge with en=1:
  - If cnt==DIV-1: cnt←0 and a step occurs.
  - Otherwise cnt←cnt+1.
- When en=0: cnt, pos, dir and mode_q hold, and step←0.
- On a step edge:
  - mode_q←mode.
  - pos and dir are updated by the rules below, using the newly sampled mode applied to the old pos.
  - step←1.
- On all other edges, step←0.
- Position rules:
  - LEFT: pos←(pos==N_LED-1) ? 0 : pos+1.
  - RIGHT: pos←(pos==0) ? N_LED-1 : pos-1.
  - BOUNCE, dir=UP: if pos==N_LED-1, then dir←DOWN and pos←N_LED-2; else pos+1.
  - BOUNCE, dir=DOWN: if pos==0, then dir←UP and pos←1; else pos-1. The end LEDs are never shown twice in a row.
  - BAR: same update as LEFT.
  - Any step taken in a mode other than BOUNCE forces dir←UP.
- led decode is combinational from registered pos and mode_q only, so there are no glitches from the mode pin:
  - LEFT/RIGHT/BOUNCE: one-hot, led = 1 << pos.
  - BAR: thermometer, led[i] = (i ≤ pos). At pos=N_LED-1 all LEDs are on; the next step returns to a single LED 0.
- A mode change between steps has no visible effect until the next step.
- pos is never ≥ N_LED, including for non-power-of-two N_LED.

## Timing
- Reset values (one clk edge with rst=1):
  - cnt=0, pos=0, dir=UP, mode_q=00 (LEFT), step=0.
  - Hence led = one-hot bit 0 (8'b0000_0001 for N_LED=8).
- rst asserted mid-count or mid-bounce returns to the reset values on that edge, regardless of en or mode.
- Step cadence:
  - The first step occurs on the DIV-th enabled edge after reset.
  - Subsequent steps occur every DIV enabled edges.
  - en-low cycles stretch the period without losing the accumulated count.
- DIV=1: a step occurs on every enabled edge; step stays high continuously while en=1.
- Latency: led, pos and step all change on the same edge (step edge + 0). Output is registered-state decode, with no further pipeline.
- Simultaneous events:
  - rst with a step: rst wins, step=0.
  - en falling on the would-be step edge: no step.
  - mode change on a step edge: the new mode is applied on that edge.

## Test plan
- Reset/idle: assert rst 2 cycles with en=1, mode=11 -> led=0000_0001, pos=0, step=0. Hold en=0 for 20 cycles -> outputs unchanged.
- LEFT wrap: N_LED=8, DIV=4, mode=00, en=1 for 40 cycles -> step pulses every 4th edge. led sequence 01,02,04,…,80,01 with a wrap after pos=7. Exactly 10 steps.
- BOUNCE ends: N_LED=5, DIV=1, mode=10 -> pos sequence 1,2,3,4,3,2,1,0,1,2. No repeated endpoint; led stays one-hot.
- BAR + mode switch: N_LED=4, DIV=2, mode=11 -> led 0011,0111,1111,0001. Switch to mode=01 between steps with pos=0 -> led unchanged until the next step, then 1000 (pos=3).
- en gating: DIV=5, enable 3 cycles, disable 10, enable 2 -> exactly one step, on the 5th enabled edge. cnt is held during the gap.
- Reset mid-run: during BOUNCE with dir=DOWN, pos=3, pulse rst on a step edge -> pos=0, dir=UP, led=bit 0, step=0. The next step (mode=10) gives pos=1.
